// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle with the carry chained through a register.
// Reports carry, borrow and signed overflow through a start/busy/done handshake.
module serial_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             inputc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             sub_q;

    logic             last_c;
    logic             load_c;
    logic [DIGIT:0]   dsum_c;
    logic             msb_cin_c;
    logic [WIDTH-1:0] res_next_c;

    assign last_c = (cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and operand-load decision
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    load_c     = 1'b1;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_RUN;
                    load_c     = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operands are shifted right, so the active digit is always the low DIGIT bits
    always_comb begin
        dsum_c     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        msb_cin_c  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum_c[DIGIT-1];
        res_next_c = (res_q >> DIGIT) | (WIDTH'(dsum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            outc     <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            busy <= (state_next == S_RUN);
            done <= (state_next == S_DONE);
            if (load_c) begin
                a_q     <= input1;
                b_q     <= sub ? ~input2 : input2;
                carry_q <= sub ? ~inputc : inputc;
                sub_q   <= sub;
                cnt     <= '0;
            end else if (state == S_RUN) begin
                a_q     <= a_q >> DIGIT;
                b_q     <= b_q >> DIGIT;
                res_q   <= res_next_c;
                carry_q <= dsum_c[DIGIT];
                if (last_c) begin
                    cnt      <= '0;
                    sum      <= res_next_c;
                    outc     <= dsum_c[DIGIT];
                    borrow   <= sub_q & ~dsum_c[DIGIT];
                    overflow <= msb_cin_c ^ dsum_c[DIGIT];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three parameter sets share one operand bus, one selected at a time.
// Directed table, handshake corner sequences and random operands against an arithmetic model.
module tb_serial_addsub;

    logic        clk;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [2:0]  start_v;
    logic [2:0]  rst_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  outc_v;
    logic [2:0]  bor_v;
    logic [2:0]  ovf_v;
    logic [15:0] sum16;
    logic [7:0]  sum8;
    logic [31:0] sum32;

    int     sel;
    longint cur_sum;
    logic   cur_busy, cur_done, cur_outc, cur_bor, cur_ovf;
    int     tests;
    int     fails;

    typedef struct {
        bit     sb;
        longint aa;
        longint bb;
        bit     c;
        longint es;
        bit     eo;
        bit     eb;
        bit     ev;
    } vec_t;

    vec_t tbl[6];

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sub(sub),
        .input1(a[15:0]), .input2(b[15:0]), .inputc(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum16),
        .outc(outc_v[0]), .borrow(bor_v[0]), .overflow(ovf_v[0])
    );

    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sub(sub),
        .input1(a[7:0]), .input2(b[7:0]), .inputc(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum8),
        .outc(outc_v[1]), .borrow(bor_v[1]), .overflow(ovf_v[1])
    );

    serial_addsub #(.WIDTH(32), .DIGIT(1)) u_dut32 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .sub(sub),
        .input1(a), .input2(b), .inputc(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum32),
        .outc(outc_v[2]), .borrow(bor_v[2]), .overflow(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_sum  = 0;
        cur_busy = busy_v[0];
        cur_done = done_v[0];
        cur_outc = outc_v[0];
        cur_bor  = bor_v[0];
        cur_ovf  = ovf_v[0];
        case (sel)
            1: cur_sum = longint'(sum8);
            2: cur_sum = longint'(sum32);
            default: cur_sum = longint'(sum16);
        endcase
        if (sel == 1 || sel == 2) begin
            cur_busy = busy_v[sel];
            cur_done = done_v[sel];
            cur_outc = outc_v[sel];
            cur_bor  = bor_v[sel];
            cur_ovf  = ovf_v[sel];
        end
    end

    function automatic int width_of(input int s);
        return (s == 1) ? 8 : ((s == 2) ? 32 : 16);
    endfunction

    function automatic int lat_of(input int s);
        return (s == 1) ? 1 : ((s == 2) ? 32 : 4);
    endfunction

    // Reference: true integer result, carry = no unsigned wrap below 0 / above 2^w, overflow = signed range
    function automatic void model(input int w, input bit s, input longint aa, input longint bb,
                                  input bit c, output longint rs, output bit ro, output bit rb,
                                  output bit rv);
        longint m, sa, sbv, ci, raw, sres;
        m   = longint'(1) << w;
        ci  = longint'(c);
        sa  = (aa >= m / 2) ? aa - m : aa;
        sbv = (bb >= m / 2) ? bb - m : bb;
        if (!s) begin
            raw  = aa + bb + ci;
            ro   = (raw >= m);
            sres = sa + sbv + ci;
        end else begin
            raw  = aa - bb - ci;
            ro   = (raw >= 0);
            sres = sa - sbv - ci;
        end
        rs = ((raw % m) + m) % m;
        rb = s & ~ro;
        rv = (sres < -(m / 2)) || (sres >= m / 2);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc  = 0;
        while (!cur_done && lat < 64) begin
            bc += int'(cur_busy);
            @(negedge clk);
            lat++;
        end
    endtask

    // Returns at the negedge where done is seen (or the wait bound expires)
    task automatic run_op(input int s, input bit sb, input longint aa, input longint bb,
                          input bit c, output int lat, output int bc);
        @(negedge clk);
        sel        = s;
        sub        = sb;
        a          = 32'(aa);
        b          = 32'(bb);
        cin        = c;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        wait_done(0, lat, bc);
    endtask

    initial begin
        int     lat, bc, dn, w;
        longint es, aa, bb;
        bit     eo, eb, ev, sb, c;

        tests   = 0;
        fails   = 0;
        sel     = 0;
        a       = '0;
        b       = '0;
        sub     = 1'b0;
        cin     = 1'b0;
        start_v = '0;
        rst_v   = '1;

        tbl[0] = '{1'b0, 'h1234, 'h4321, 1'b0, 'h5555, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 'h7FFF, 'h0001, 1'b0, 'h8000, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 'hFFFF, 'h0000, 1'b1, 'h0000, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 'h0005, 'h0007, 1'b0, 'hFFFE, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 'h0010, 'h0001, 1'b1, 'h000E, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 'h8000, 'h0001, 1'b0, 'h7FFF, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_sum", cur_sum, 0);
        chk("reset_ctl", longint'({cur_busy, cur_done, cur_outc, cur_bor, cur_ovf}), 0);
        rst_v = '0;

        for (int i = 0; i < 6; i++) begin
            run_op(0, tbl[i].sb, tbl[i].aa, tbl[i].bb, tbl[i].c, lat, bc);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
            chk($sformatf("vec%0d_busy_at_done", i), longint'(cur_busy), 0);
            chk($sformatf("vec%0d_sum", i), cur_sum, tbl[i].es);
            chk($sformatf("vec%0d_flags", i), longint'({cur_outc, cur_bor, cur_ovf}),
                longint'({tbl[i].eo, tbl[i].eb, tbl[i].ev}));
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), longint'(cur_done), 0);
        end

        // start re-pulsed with other operands during RUN must be ignored
        @(negedge clk);
        sel = 0; sub = 1'b0; a = 32'h1234; b = 32'h4321; cin = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        sub = 1'b1; a = 32'hAAAA; b = 32'h1111; cin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(2, lat, bc);
        chk("ignore_start_latency", lat, 4);
        chk("ignore_start_sum", cur_sum, 'h5555);
        chk("ignore_start_flags", longint'({cur_outc, cur_bor, cur_ovf}), 0);

        // start held in the DONE cycle launches the next operation back to back
        run_op(0, 1'b1, 'h0005, 'h0007, 1'b0, lat, bc);
        sub = 1'b0; a = 32'h7FFF; b = 32'h0001; cin = 1'b0;
        start_v[0] = 1'b1;
        chk("b2b_first_sum", cur_sum, 'hFFFE);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_done_dropped", longint'(cur_done), 0);
        chk("b2b_busy", longint'(cur_busy), 1);
        chk("b2b_sum_held", cur_sum, 'hFFFE);
        wait_done(0, lat, bc);
        chk("b2b_latency", lat, 4);
        chk("b2b_second_sum", cur_sum, 'h8000);
        chk("b2b_second_flags", longint'({cur_outc, cur_bor, cur_ovf}), 1);

        // reset at cnt = 2 discards the operation
        @(negedge clk);
        sel = 0; sub = 1'b0; a = 32'h1111; b = 32'h2222; cin = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        chk("midrun_reset_sum", cur_sum, 0);
        chk("midrun_reset_ctl", longint'({cur_busy, cur_done, cur_outc, cur_bor, cur_ovf}), 0);
        rst_v[0] = 1'b0;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            dn += int'(cur_done);
        end
        chk("midrun_reset_no_done", dn, 0);

        // Parameter sweep directed cases
        run_op(1, 1'b0, 'h7F, 'h01, 1'b0, lat, bc);
        chk("w8_latency", lat, 1);
        chk("w8_sum", cur_sum, 'h80);
        chk("w8_flags", longint'({cur_outc, cur_bor, cur_ovf}), 1);
        run_op(2, 1'b0, 'hFFFF_FFFF, 'h1, 1'b0, lat, bc);
        chk("w32_latency", lat, 32);
        chk("w32_sum", cur_sum, 0);
        chk("w32_flags", longint'({cur_outc, cur_bor, cur_ovf}), 4);

        // Random operands on every parameter set
        for (int s = 0; s < 3; s++) begin
            w = width_of(s);
            for (int i = 0; i < ((s == 2) ? 30 : 120); i++) begin
                aa = longint'($urandom) & ((longint'(1) << w) - 1);
                bb = longint'($urandom) & ((longint'(1) << w) - 1);
                sb = 1'($urandom_range(0, 1));
                c  = 1'($urandom_range(0, 1));
                run_op(s, sb, aa, bb, c, lat, bc);
                model(w, sb, aa, bb, c, es, eo, eb, ev);
                chk($sformatf("rand_w%0d_%0d_latency", w, i), lat, lat_of(s));
                chk($sformatf("rand_w%0d_%0d_sum", w, i), cur_sum, es);
                chk($sformatf("rand_w%0d_%0d_flags", w, i),
                    longint'({cur_outc, cur_bor, cur_ovf}), longint'({eo, eb, ev}));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
